// File: rtl/digital_lock_ctrl.sv
// rtl/digital_lock_ctrl.sv - digit-entry lock controller with password change and timed lockout
module digital_lock_ctrl #(
    parameter int                      PW_LEN      = 4,
    parameter logic [2*PW_LEN-1:0]     DEFAULT_PW  = 8'b00_01_10_01,
    parameter int                      MAX_FAIL    = 3,
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_all,
    input  logic       enter,
    input  logic [1:0] mod3_btn,
    input  logic       mode,
    input  logic       lock_rst,
    output logic       Q,
    output logic [2:0] led_4,
    output logic       alarm,
    output logic [2:0] digit_cnt
);

    localparam int              IW        = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int              LW        = $clog2(LOCK_CYCLES + 1);
    localparam logic [2:0]      LAST_IDX  = 3'(PW_LEN - 1);
    localparam logic [2:0]      MAX_FAIL3 = 3'(MAX_FAIL);
    localparam logic [LW-1:0]   LOCK_INIT = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_SETPW, S_LOCKOUT
    } state_t;

    state_t                   state, state_n;
    logic [PW_LEN-1:0][1:0]   entry_buf, entry_buf_n, entry_ins;
    logic [PW_LEN-1:0][1:0]   pw, pw_n;
    logic [2:0]               digit_cnt_n;
    logic [2:0]               fail_cnt, fail_cnt_n, fail_inc;
    logic [LW-1:0]            lock_cnt, lock_cnt_n;
    logic                     enter_q;
    logic                     keypress, valid_key, last_digit;
    logic                     q_d, alarm_d;
    logic [2:0]               led_d;
    logic [IW-1:0]            idx;

    assign keypress   = enter & ~enter_q;
    assign valid_key  = keypress && (mod3_btn != 2'd3);
    assign last_digit = (digit_cnt == LAST_IDX);
    assign idx        = digit_cnt[IW-1:0];
    assign fail_inc   = fail_cnt + 3'd1;

    always_comb begin
        entry_ins      = entry_buf;
        entry_ins[idx] = mod3_btn;
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state     <= S_IDLE;
            entry_buf <= '0;
            pw        <= DEFAULT_PW;
            digit_cnt <= 3'd0;
            fail_cnt  <= 3'd0;
            lock_cnt  <= '0;
            enter_q   <= 1'b0;
            Q         <= 1'b0;
            alarm     <= 1'b0;
            led_4     <= MAX_FAIL3;
        end else begin
            state     <= state_n;
            entry_buf <= entry_buf_n;
            pw        <= pw_n;
            digit_cnt <= digit_cnt_n;
            fail_cnt  <= fail_cnt_n;
            lock_cnt  <= lock_cnt_n;
            enter_q   <= enter;
            Q         <= q_d;
            alarm     <= alarm_d;
            led_4     <= led_d;
        end
    end

    always_comb begin
        state_n     = state;
        entry_buf_n = entry_buf;
        pw_n        = pw;
        digit_cnt_n = digit_cnt;
        fail_cnt_n  = fail_cnt;
        lock_cnt_n  = lock_cnt;
        case (state)
            S_IDLE, S_ENTRY: begin
                if (lock_rst) begin
                    state_n     = S_IDLE;
                    digit_cnt_n = 3'd0;
                end else if (valid_key) begin
                    entry_buf_n = entry_ins;
                    digit_cnt_n = digit_cnt + 3'd1;
                    state_n     = last_digit ? S_CHECK : S_ENTRY;
                end
            end
            S_CHECK: begin
                digit_cnt_n = 3'd0;
                if (entry_buf == pw) begin
                    state_n    = S_OPEN;
                    fail_cnt_n = 3'd0;
                end else begin
                    fail_cnt_n = fail_inc;
                    if (fail_inc >= MAX_FAIL3) begin
                        state_n    = S_LOCKOUT;
                        lock_cnt_n = LOCK_INIT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                if (lock_rst) begin
                    state_n = S_IDLE;
                end else if (keypress && mode) begin
                    state_n     = S_SETPW;
                    digit_cnt_n = 3'd0;
                end
            end
            S_SETPW: begin
                // The live password is only written once the whole new code is in.
                if (lock_rst) begin
                    state_n     = S_IDLE;
                    digit_cnt_n = 3'd0;
                end else if (valid_key) begin
                    entry_buf_n = entry_ins;
                    if (last_digit) begin
                        pw_n        = entry_ins;
                        digit_cnt_n = 3'd0;
                        state_n     = S_OPEN;
                    end else begin
                        digit_cnt_n = digit_cnt + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_n    = S_IDLE;
                    fail_cnt_n = 3'd0;
                end else begin
                    lock_cnt_n = lock_cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        q_d     = (state == S_OPEN) || (state == S_SETPW);
        alarm_d = (state == S_LOCKOUT);
        led_d   = MAX_FAIL3 - fail_cnt;
    end

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// tb/tb_digital_lock_ctrl.sv - directed self-checking bench for digital_lock_ctrl
module tb_digital_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_all = 1'b0;
    logic       enter = 1'b0;
    logic [1:0] mod3_btn = 2'd0;
    logic       mode = 1'b0;
    logic       lock_rst = 1'b0;
    logic       Q;
    logic [2:0] led_4;
    logic       alarm;
    logic [2:0] digit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    digital_lock_ctrl dut (
        .clk       (clk),
        .rst_all   (rst_all),
        .enter     (enter),
        .mod3_btn  (mod3_btn),
        .mode      (mode),
        .lock_rst  (lock_rst),
        .Q         (Q),
        .led_4     (led_4),
        .alarm     (alarm),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] d);
        mod3_btn = d;
        enter    = 1'b1;
        tick();
        enter    = 1'b0;
        tick();
    endtask

    // Four presses plus one edge so the registered outputs reflect the CHECK result.
    task automatic enter_code(input logic [1:0] a, b, c, d);
        press(a);
        press(b);
        press(c);
        press(d);
        tick();
    endtask

    task automatic pulse_lock_rst();
        lock_rst = 1'b1;
        tick();
        lock_rst = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_all = 1'b1;
        tick();
        rst_all = 1'b0;
    endtask

    task automatic test_reset();
        enter = 1'b1;
        mod3_btn = 2'd2;
        do_reset();
        enter = 1'b0;
        tick();
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL reset_q got %0b want 0", Q); end
        n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got %0b want 0", alarm); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL reset_led got %0d want 3", led_4); end
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", digit_cnt); end
    endtask

    task automatic test_open();
        press(2'd1);
        press(2'd2);
        press(2'd1);
        n_checks++; if (digit_cnt !== 3'd3) begin n_fail++; $display("FAIL open_cnt3 got %0d want 3", digit_cnt); end
        press(2'd0);
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL open_latency_early got %0b want 0", Q); end
        tick();
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL open_q got %0b want 1", Q); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL open_led got %0d want 3", led_4); end
        n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL open_alarm got %0b want 0", alarm); end
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL open_cnt got %0d want 0", digit_cnt); end
        pulse_lock_rst();
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL relock_q got %0b want 0", Q); end
    endtask

    task automatic test_lockout();
        int cnt;
        int bad_cnt;
        enter_code(2'd0, 2'd0, 2'd0, 2'd0);
        n_checks++; if (led_4 !== 3'd2) begin n_fail++; $display("FAIL wrong1_led got %0d want 2", led_4); end
        enter_code(2'd0, 2'd0, 2'd0, 2'd0);
        n_checks++; if (led_4 !== 3'd1) begin n_fail++; $display("FAIL wrong2_led got %0d want 1", led_4); end
        enter_code(2'd0, 2'd0, 2'd0, 2'd0);
        n_checks++; if (led_4 !== 3'd0) begin n_fail++; $display("FAIL wrong3_led got %0d want 0", led_4); end
        cnt = 0;
        bad_cnt = 0;
        mod3_btn = 2'd1;
        for (int i = 0; i < 40; i++) begin
            if (!alarm) break;
            cnt++;
            if (digit_cnt !== 3'd0) bad_cnt++;
            enter = (i < 10) ? i[0] : 1'b0;
            tick();
        end
        enter = 1'b0;
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL lockout_len got %0d want 16", cnt); end
        n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL lockout_keys got %0d bad cycles want 0", bad_cnt); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL lockout_exit_led got %0d want 3", led_4); end
        n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL lockout_exit_alarm got %0b want 0", alarm); end
    endtask

    task automatic test_held_press();
        mod3_btn = 2'd1;
        enter = 1'b1;
        repeat (5) tick();
        enter = 1'b0;
        tick();
        n_checks++; if (digit_cnt !== 3'd1) begin n_fail++; $display("FAIL held_cnt got %0d want 1", digit_cnt); end
        press(2'd3);
        n_checks++; if (digit_cnt !== 3'd1) begin n_fail++; $display("FAIL invalid_cnt got %0d want 1", digit_cnt); end
        lock_rst = 1'b1;
        mod3_btn = 2'd2;
        enter = 1'b1;
        tick();
        lock_rst = 1'b0;
        enter = 1'b0;
        tick();
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL lockrst_key_cnt got %0d want 0", digit_cnt); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL lockrst_led got %0d want 3", led_4); end
    endtask

    task automatic test_setpw();
        enter_code(2'd1, 2'd2, 2'd1, 2'd0);
        mode = 1'b1;
        press(2'd1);
        mode = 1'b0;
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL setpw_entry_cnt got %0d want 0", digit_cnt); end
        press(2'd2);
        press(2'd2);
        press(2'd2);
        press(2'd2);
        tick();
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL setpw_q got %0b want 1", Q); end
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL setpw_done_cnt got %0d want 0", digit_cnt); end
        pulse_lock_rst();
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL setpw_relock_q got %0b want 0", Q); end
        enter_code(2'd1, 2'd2, 2'd1, 2'd0);
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL old_code_q got %0b want 0", Q); end
        n_checks++; if (led_4 !== 3'd2) begin n_fail++; $display("FAIL old_code_led got %0d want 2", led_4); end
        enter_code(2'd2, 2'd2, 2'd2, 2'd2);
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL new_code_q got %0b want 1", Q); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL new_code_led got %0d want 3", led_4); end
    endtask

    task automatic test_reset_after_change();
        do_reset();
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL rst_chg_q got %0b want 0", Q); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL rst_chg_led got %0d want 3", led_4); end
        enter_code(2'd1, 2'd2, 2'd1, 2'd0);
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL rst_chg_default_q got %0b want 1", Q); end
    endtask

    task automatic test_setpw_abort();
        mode = 1'b1;
        press(2'd0);
        mode = 1'b0;
        press(2'd2);
        press(2'd0);
        n_checks++; if (digit_cnt !== 3'd2) begin n_fail++; $display("FAIL abort_partial_cnt got %0d want 2", digit_cnt); end
        pulse_lock_rst();
        n_checks++; if (Q !== 1'b0) begin n_fail++; $display("FAIL abort_q got %0b want 0", Q); end
        n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_cnt got %0d want 0", digit_cnt); end
        enter_code(2'd1, 2'd2, 2'd1, 2'd0);
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL abort_old_code_q got %0b want 1", Q); end
        pulse_lock_rst();
    endtask

    task automatic test_reset_in_lockout();
        enter_code(2'd2, 2'd0, 2'd0, 2'd0);
        enter_code(2'd2, 2'd0, 2'd0, 2'd0);
        enter_code(2'd2, 2'd0, 2'd0, 2'd0);
        tick();
        n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL pre_rst_alarm got %0b want 1", alarm); end
        do_reset();
        n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL rst_lock_alarm got %0b want 0", alarm); end
        n_checks++; if (led_4 !== 3'd3) begin n_fail++; $display("FAIL rst_lock_led got %0d want 3", led_4); end
        enter_code(2'd1, 2'd2, 2'd1, 2'd0);
        n_checks++; if (Q !== 1'b1) begin n_fail++; $display("FAIL rst_lock_open_q got %0b want 1", Q); end
    endtask

    initial begin
        test_reset();
        test_open();
        test_lockout();
        test_held_press();
        test_setpw();
        test_reset_after_change();
        test_setpw_abort();
        test_reset_in_lockout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
